// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit positions and the hex-to-segment table shared by the display driver
package seg7_pkg;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  // Entry n occupies bits [7n+6:7n]; bit 0 = segment a ... bit 6 = segment g, 1 = lit.
  localparam logic [111:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
    return SEG7_TABLE[7*nib +: 7];
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-high a..g segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = seg7_hex(nib_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit hex display with frame-synchronous shadow commit
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int LZ_BLANK       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic                    pending,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SEG_INV = ACTIVE_LOW_SEG != 0 ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_INV = ACTIVE_LOW_AN != 0 ? '1 : '0;

  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic                    frame_q;
  logic [4*NUM_DIGITS-1:0] sh_val_q, disp_val_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_blank_q, disp_dp_q, disp_blank_q;
  logic                    pending_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d, lz;
  logic                    slot_tick, last_digit, commit, cur_blank, all_zero;
  logic [3:0]              cur_nib;
  logic [6:0]              hex_seg;

  assign slot_tick  = enable && cnt_q == CW'(PRESCALE - 1);
  assign last_digit = idx_q == IW'(NUM_DIGITS - 1);
  assign commit     = slot_tick && last_digit && pending_q;
  assign cur_nib    = disp_val_q[4*idx_q +: 4];

  seg7_hex_decode u_dec (
    .nib_i (cur_nib),
    .seg_o (hex_seg)
  );

  // lz[i] is set when digit i and every digit above it are zero
  always_comb begin
    lz = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && disp_val_q[4*i +: 4] == 4'h0;
      lz[i] = all_zero;
    end
  end

  // current digit's lit pattern in active-high form; dark when scanning is off
  always_comb begin
    cur_blank = disp_blank_q[idx_q] || (LZ_BLANK != 0 && idx_q != '0 && lz[idx_q]);
    seg_d = '0;
    seg_d[SEG_DP] = enable && disp_dp_q[idx_q];
    seg_d[SEG_G:SEG_A] = enable && !cur_blank ? hex_seg : 7'h00;
    an_d = enable ? NUM_DIGITS'(1) << idx_q : '0;
  end

  // prescaler, digit index and frame pulse; all hold while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= slot_tick ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
      idx_q   <= !slot_tick ? idx_q : last_digit ? '0 : idx_q + 1'b1;
      frame_q <= slot_tick && last_digit;
    end
  end

  // shadow capture on load, display commit only at the frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (load) begin
        sh_val_q   <= value;
        sh_dp_q    <= dp_in;
        sh_blank_q <= blank_in;
      end
      if (commit) begin
        disp_val_q   <= sh_val_q;
        disp_dp_q    <= sh_dp_q;
        disp_blank_q <= sh_blank_q;
      end
      pending_q <= load || (pending_q && !commit);
    end
  end

  // output registers apply the pin polarity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_INV;
      an_q  <= AN_INV;
    end else begin
      seg_q <= seg_d ^ SEG_INV;
      an_q  <= an_d ^ AN_INV;
    end
  end

  assign pending    = pending_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed vectors on an active-low build and an active-high LZ-blanking build
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in;
  logic        pend0, pend1, ft0, ft1;
  logic [7:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1), .LZ_BLANK(0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .pending(pend0), .seg(seg0), .an(an0), .frame_tick(ft0)
  );
  seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0), .LZ_BLANK(1)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .pending(pend1), .seg(seg1), .an(an1), .frame_tick(ft1)
  );

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t vt[6];
  logic [7:0] hex_tab[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sync_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ft0 && n < 40);
    chk("frame_sync", {31'd0, ft0}, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value = v;
    dp_in = dp;
    blank_in = bl;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pending_set0", {31'd0, pend0}, 32'd1);
    chk("pending_set1", {31'd0, pend1}, 32'd1);
  endtask

  task automatic check_inactive(input string tag);
    chk({tag, "_seg0"}, {24'd0, seg0}, 32'hFF);
    chk({tag, "_an0"}, {28'd0, an0}, 32'hF);
    chk({tag, "_seg1"}, {24'd0, seg1}, 32'h00);
    chk({tag, "_an1"}, {28'd0, an1}, 32'h0);
  endtask

  task automatic check_digits(input logic [31:0] e0, input logic [31:0] e1, input string tag);
    logic [7:0] s0;
    logic [3:0] oh;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      s0 = ~e0[8*d +: 8];
      oh = 4'(1 << d);
      chk($sformatf("%s_d%0d_seg0", tag, d), {24'd0, seg0}, {24'd0, s0});
      chk($sformatf("%s_d%0d_an0", tag, d), {28'd0, an0}, {28'd0, ~oh});
      chk($sformatf("%s_d%0d_seg1", tag, d), {24'd0, seg1}, {24'd0, e1[8*d +: 8]});
      chk($sformatf("%s_d%0d_an1", tag, d), {28'd0, an1}, {28'd0, oh});
      if (d < 3) repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [3:0] nb;
    logic [7:0] p;
    vt[0] = '{16'h12AF, 4'b0100, 4'b0000, 32'h06DB7771, 32'h06DB7771};
    vt[1] = '{16'h0050, 4'b0000, 4'b0000, 32'h3F3F6D3F, 32'h00006D3F};
    vt[2] = '{16'h0000, 4'b0000, 4'b0000, 32'h3F3F3F3F, 32'h0000003F};
    vt[3] = '{16'h0000, 4'b0000, 4'b0001, 32'h3F3F3F00, 32'h00000000};
    vt[4] = '{16'h0800, 4'b1111, 4'b0000, 32'hBFFFBFBF, 32'h80FFBFBF};
    vt[5] = '{16'h3456, 4'b0000, 4'b0010, 32'h4F66007D, 32'h4F66007D};
    hex_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    rst = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
    @(negedge clk);
    check_inactive("reset");
    chk("reset_pend0", {31'd0, pend0}, 32'd0);
    chk("reset_ft0", {31'd0, ft0}, 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    // scan order after reset shows the all-zero display
    sync_frame();
    check_digits(vt[2].e0, vt[2].e1, "scan");
    sync_frame();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ft0 && n < 40);
    chk("frame_period", n, 16);
    @(negedge clk);
    chk("frame_width", {31'd0, ft0}, 32'd0);
    // table of directed values
    for (int i = 0; i < 6; i++) begin
      do_load(vt[i].v, vt[i].dp, vt[i].bl);
      sync_frame();
      chk($sformatf("vec%0d_commit_pend0", i), {31'd0, pend0}, 32'd0);
      chk($sformatf("vec%0d_commit_pend1", i), {31'd0, pend1}, 32'd0);
      check_digits(vt[i].e0, vt[i].e1, $sformatf("vec%0d", i));
    end
    // decode sweep: every nibble on all digits
    for (int k = 0; k < 16; k++) begin
      nb = 4'(k);
      p = hex_tab[k];
      do_load({nb, nb, nb, nb}, 4'b0000, 4'b0000);
      sync_frame();
      check_digits({p, p, p, p}, k == 0 ? 32'h0000003F : {p, p, p, p}, $sformatf("hex%0h", k));
    end
    // collision: second load lands on the commit edge
    sync_frame();
    do_load(vt[0].v, vt[0].dp, vt[0].bl);
    repeat (14) @(negedge clk);
    value = vt[5].v; dp_in = vt[5].dp; blank_in = vt[5].bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("coll_ft", {31'd0, ft0}, 32'd1);
    chk("coll_pend", {31'd0, pend0}, 32'd1);
    check_digits(vt[0].e0, vt[0].e1, "coll_first");
    sync_frame();
    chk("coll_pend_clear", {31'd0, pend0}, 32'd0);
    check_digits(vt[5].e0, vt[5].e1, "coll_second");
    // enable drop mid-frame while digit 1 is showing
    sync_frame();
    repeat (6) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_inactive("dis");
    do_load(vt[1].v, vt[1].dp, vt[1].bl);
    repeat (20) @(negedge clk);
    chk("dis_pend_hold", {31'd0, pend0}, 32'd1);
    check_inactive("dis_hold");
    enable = 1'b1;
    @(negedge clk);
    chk("reen_an0_d1", {28'd0, an0}, 32'hD);
    chk("reen_an1_d1", {28'd0, an1}, 32'h2);
    repeat (2) @(negedge clk);
    chk("reen_an0_d2", {28'd0, an0}, 32'hB);
    chk("reen_an1_d2", {28'd0, an1}, 32'h4);
    sync_frame();
    chk("reen_commit", {31'd0, pend0}, 32'd0);
    check_digits(vt[1].e0, vt[1].e1, "reen");
    // asynchronous reset between edges drops a pending load
    do_load(vt[4].v, vt[4].dp, vt[4].bl);
    #2 rst = 1'b1;
    #1;
    check_inactive("arst");
    chk("arst_pend0", {31'd0, pend0}, 32'd0);
    chk("arst_pend1", {31'd0, pend1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sync_frame();
    chk("arst_no_commit", {31'd0, pend0}, 32'd0);
    check_digits(vt[2].e0, vt[2].e1, "arst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
